// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-side branch predictor: counter encodings,
// the saturating counter update and the table index-width derivation.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_next(ctr_e ctr, logic taken);
    ctr_e nxt;
    nxt = ctr;
    case (ctr)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = CTR_WNT;
    endcase
    return nxt;
  endfunction

  function automatic int idx_w(int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute-stage resolve and statistics signals of the branch
// predictor. The pipeline side is the master, the predictor the slave.
interface branch_predictor_if #(
  parameter int PC_W = 16
);
  logic [PC_W-1:0] if_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

  logic            ex_valid;
  logic            ex_is_cti;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;

  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic [15:0]     br_count;
  logic [15:0]     mp_count;

  modport master (
    output if_pc, ex_valid, ex_is_cti, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, br_count, mp_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_cti, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, br_count, mp_count
  );
endinterface

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer storage: two combinational read ports
// (fetch lookup and resolve lookup) and one synchronous write port.
module btb_array
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 16,
  parameter int IDX_W   = idx_w(ENTRIES),
  parameter int TAG_W   = PC_W - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [IDX_W-1:0] ra_idx,
  output logic             ra_valid,
  output logic [TAG_W-1:0] ra_tag,
  output logic [PC_W-1:0]  ra_target,
  output ctr_e             ra_ctr,

  input  logic [IDX_W-1:0] rb_idx,
  output logic             rb_valid,
  output logic [TAG_W-1:0] rb_tag,
  output logic [PC_W-1:0]  rb_target,
  output ctr_e             rb_ctr,

  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  ctr_e             wr_ctr
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  ctr_e             ctr_q    [ENTRIES];

  // NOTE: every entry is cleared on reset so a stale valid bit can never
  // produce a hit; this forces a flop array rather than an SRAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      // NOTE: non-blocking assignments keep every flop update ordered
      // against the same pre-edge values, whatever the block ordering.
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

  assign ra_valid  = valid_q[ra_idx];
  assign ra_tag    = tag_q[ra_idx];
  assign ra_target = target_q[ra_idx];
  assign ra_ctr    = ctr_q[ra_idx];

  assign rb_valid  = valid_q[rb_idx];
  assign rb_tag    = tag_q[rb_idx];
  assign rb_target = target_q[rb_idx];
  assign rb_ctr    = ctr_q[rb_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: BTB lookup for IF, training and mispredict
// detection from the EX resolve, plus saturating branch statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bus
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [15:0]     CNT_MAX = 16'hFFFF;

  logic             f_valid, x_valid;
  logic [TAG_W-1:0] f_tag, x_tag;
  logic [PC_W-1:0]  f_target, x_target;
  ctr_e             f_ctr, x_ctr;
  logic             f_hit, x_hit;
  logic             resolve;

  logic             wr_en;
  logic [PC_W-1:0]  wr_target;
  ctr_e             wr_ctr;

  logic [15:0]      br_count_q, mp_count_q;

  btb_array #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_idx    (bus.if_pc[IDX_W-1:0]),
    .ra_valid  (f_valid),
    .ra_tag    (f_tag),
    .ra_target (f_target),
    .ra_ctr    (f_ctr),
    .rb_idx    (bus.ex_pc[IDX_W-1:0]),
    .rb_valid  (x_valid),
    .rb_tag    (x_tag),
    .rb_target (x_target),
    .rb_ctr    (x_ctr),
    .wr_en     (wr_en),
    .wr_idx    (bus.ex_pc[IDX_W-1:0]),
    .wr_tag    (bus.ex_pc[PC_W-1:IDX_W]),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  // Lookup reads registered state only, so a same-cycle update is not seen.
  assign f_hit           = f_valid && (f_tag == bus.if_pc[PC_W-1:IDX_W]);
  assign bus.pred_taken  = f_hit && f_ctr[1];
  assign bus.pred_target = bus.pred_taken ? f_target : bus.if_pc + PC_ONE;

  assign resolve         = bus.ex_valid && bus.ex_is_cti;
  assign x_hit           = x_valid && (x_tag == bus.ex_pc[PC_W-1:IDX_W]);
  assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_ONE;
  assign bus.mispredict  = resolve &&
                           ((bus.ex_taken != bus.ex_pred_taken) ||
                            (bus.ex_taken && bus.ex_pred_taken &&
                             (bus.ex_target != bus.ex_pred_target)));

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wr_en     = 1'b0;
    wr_target = x_target;
    wr_ctr    = x_ctr;
    if (resolve) begin
      if (x_hit) begin
        wr_en  = 1'b1;
        wr_ctr = ctr_next(x_ctr, bus.ex_taken);
        if (bus.ex_taken) wr_target = bus.ex_target;
      end else if (bus.ex_taken) begin
        wr_en     = 1'b1;
        wr_ctr    = CTR_WT;
        wr_target = bus.ex_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      if (resolve && br_count_q != CNT_MAX)
        br_count_q <= br_count_q + 16'd1;
      if (bus.mispredict && mp_count_q != CNT_MAX)
        mp_count_q <= mp_count_q + 16'd1;
    end
  end

  assign bus.br_count = br_count_q;
  assign bus.mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver issues one stimulus per
// cycle and queues the reference model's answer; a monitor pops and compares.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int PC_W    = 16;
  localparam int PC_MOD  = 65536;
  localparam int CNT_SAT = 65535;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(PC_W)) bus ();

  branch_predictor #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string name;
    bit    pred_taken;
    int    pred_target;
    bit    mispredict;
    int    redirect_pc;
    int    br;
    int    mp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: one record per table slot, plain integers throughout.
  bit m_valid  [ENTRIES];
  int m_tag    [ENTRIES];
  int m_target [ENTRIES];
  int m_ctr    [ENTRIES];
  int m_br, m_mp;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = 0;
      m_ctr[i]    = 1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic bit m_hit(int pc);
    return m_valid[pc % ENTRIES] && (m_tag[pc % ENTRIES] == pc / ENTRIES);
  endfunction

  function automatic void m_lookup(int pc, output bit tk, output int tgt);
    tk  = m_hit(pc) && (m_ctr[pc % ENTRIES] >= 2);
    tgt = tk ? m_target[pc % ENTRIES] : (pc + 1) % PC_MOD;
  endfunction

  // One cycle of stimulus: drive, queue expected outputs, then advance model.
  task automatic step(string name, bit rstn, int if_pc, bit v, bit cti,
                      int ex_pc, bit tk, int tgt, bit ptk, int ptgt);
    exp_t e;
    bit   res, mp;
    int   idx;
    @(posedge clk);
    #1;
    rst_n              = rstn;
    bus.if_pc          = if_pc[PC_W-1:0];
    bus.ex_valid       = v;
    bus.ex_is_cti      = cti;
    bus.ex_pc          = ex_pc[PC_W-1:0];
    bus.ex_taken       = tk;
    bus.ex_target      = tgt[PC_W-1:0];
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt[PC_W-1:0];
    if (!rstn) model_reset();

    res = v && cti;
    mp  = res && ((tk != ptk) || (tk && ptk && tgt != ptgt));
    e.name = name;
    m_lookup(if_pc, e.pred_taken, e.pred_target);
    e.mispredict  = mp;
    e.redirect_pc = tk ? tgt : (ex_pc + 1) % PC_MOD;
    e.br          = m_br;
    e.mp          = m_mp;
    sb.push_back(e);

    if (rstn && res) begin
      idx = ex_pc % ENTRIES;
      if (m_hit(ex_pc)) begin
        m_ctr[idx] = tk ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                        : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        if (tk) m_target[idx] = tgt;
      end else if (tk) begin
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = ex_pc / ENTRIES;
        m_target[idx] = tgt;
        m_ctr[idx]    = 2;
      end
      if (m_br < CNT_SAT) m_br++;
      if (mp && m_mp < CNT_SAT) m_mp++;
    end
  endtask

  function automatic int rand_pc();
    if ($urandom_range(0, 3) == 0) return 'hFFF0 + $urandom_range(0, 15);
    return $urandom_range(0, 63);
  endfunction

  task automatic random_step(string name, bit force_mp);
    int  ex_pc, tgt, ptgt;
    bit  tk, ptk;
    ex_pc = rand_pc();
    tgt   = rand_pc();
    tk    = $urandom_range(0, 1);
    if ($urandom_range(0, 1) == 1) m_lookup(ex_pc, ptk, ptgt);
    else begin
      ptk  = $urandom_range(0, 1);
      ptgt = rand_pc();
    end
    if (force_mp) ptk = !tk;
    step(name, 1'b1, rand_pc(), force_mp || ($urandom_range(0, 3) != 0),
         force_mp || ($urandom_range(0, 3) != 0), ex_pc, tk, tgt, ptk, ptgt);
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".pred_taken"},  int'(bus.pred_taken),  int'(e.pred_taken));
        check({e.name, ".pred_target"}, int'(bus.pred_target), e.pred_target);
        check({e.name, ".mispredict"},  int'(bus.mispredict),  int'(e.mispredict));
        check({e.name, ".redirect_pc"}, int'(bus.redirect_pc), e.redirect_pc);
        check({e.name, ".br_count"},    int'(bus.br_count),    e.br);
        check({e.name, ".mp_count"},    int'(bus.mp_count),    e.mp);
      end
    end
  end

  initial begin
    rst_n              = 1'b0;
    bus.if_pc          = '0;
    bus.ex_valid       = 1'b0;
    bus.ex_is_cti      = 1'b0;
    bus.ex_pc          = '0;
    bus.ex_taken       = 1'b0;
    bus.ex_target      = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;
    model_reset();

    step("reset",          1'b0, 'h10, 0, 0, 0,    0, 0,    0, 0);
    step("reset_lookup",   1'b1, 'h10, 0, 0, 0,    0, 0,    0, 0);
    step("alloc_0010",     1'b1, 'h10, 1, 1, 'h10, 1, 'h40, 0, 'h11);
    step("hit_0010",       1'b1, 'h10, 0, 0, 0,    0, 0,    0, 0);
    repeat (3)
      step("train_taken",  1'b1, 'h10, 1, 1, 'h10, 1, 'h40, 1, 'h40);
    step("train_nt",       1'b1, 'h10, 1, 1, 'h10, 0, 'h40, 1, 'h40);
    step("still_taken",    1'b1, 'h10, 0, 0, 0,    0, 0,    0, 0);
    step("alias_0020",     1'b1, 'h20, 1, 1, 'h20, 1, 'h80, 0, 'h21);
    step("alias_lk_0010",  1'b1, 'h10, 0, 0, 0,    0, 0,    0, 0);
    step("alias_lk_0020",  1'b1, 'h20, 0, 0, 0,    0, 0,    0, 0);
    step("realloc_0010",   1'b1, 'h10, 1, 1, 'h10, 1, 'h40, 0, 'h11);
    step("stale_target",   1'b1, 'h10, 1, 1, 'h10, 1, 'h50, 1, 'h40);
    step("squashed",       1'b1, 'h10, 0, 1, 'h10, 1, 'h60, 1, 'h50);
    step("post_squash",    1'b1, 'h10, 0, 0, 0,    0, 0,    0, 0);
    step("wrap_ffff",      1'b1, 'hFFFF, 1, 1, 'hFFFF, 0, 'h1234, 1, 'h1234);
    step("back2back_a",    1'b1, 'h33, 1, 1, 'h33, 1, 'h99, 0, 'h34);
    step("back2back_b",    1'b1, 'h33, 1, 1, 'h33, 0, 'h99, 1, 'h99);
    step("back2back_chk",  1'b1, 'h33, 0, 0, 0,    0, 0,    0, 0);

    for (int i = 0; i < 2000; i++) random_step("random", 1'b0);

    for (int i = 0; i < 65540; i++) random_step("saturate", 1'b1);
    step("sat_hold",       1'b1, 'h10, 0, 0, 0,    0, 0,    0, 0);

    step("midrun_reset",   1'b0, 'h10, 1, 1, 'h10, 1, 'h40, 0, 'h11);
    step("post_reset",     1'b1, 'h10, 0, 0, 0,    0, 0,    0, 0);
    step("post_reset_lk",  1'b1, 'hFFF3, 0, 0, 0,  0, 0,    0, 0);
    for (int i = 0; i < 200; i++) random_step("random_tail", 1'b0);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
